fpu_result_collector: RTL and testbench

- Receive-side companion to add_sub_main. Accepts the R stream one 32-bit IEEE-754 single-precision result per valid cycle.
- Classifies each result and buffers it with its class in a FIFO. A consumer drains the FIFO through a valid/ready interface.
- Keeps saturating per-class statistics counters and a drop counter.
- Sits between the FPU add/sub datapath and any downstream consumer or debug readout.

---
 rtl/fpu_result_collector.sv | 157 +++++++++++++++
 tb/tb_fpu_result_collector.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_collector.sv
// fpu_result_collector
// Receive-side collector for the FPU add/sub result stream. Each incoming
// single-precision word is classified (zero / denormal / normal / inf / NaN),
// buffered with its class in a small FIFO, and drained through a
// valid/ready interface. Saturating per-class statistics and a drop counter
// with a sticky overflow flag give a debug view of the traffic.

module fpu_result_collector #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [2:0]       out_class,
    output logic             full,
    output logic             empty,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] zero_cnt,
    output logic [CNT_W-1:0] denorm_cnt,
    output logic [CNT_W-1:0] normal_cnt,
    output logic [CNT_W-1:0] inf_cnt,
    output logic [CNT_W-1:0] nan_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_DENORM = 3'd1,
        CLS_NORMAL = 3'd2,
        CLS_INF    = 3'd3,
        CLS_NAN    = 3'd4
    } cls_e;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [34:0]      r_mem [DEPTH];

    logic [CNT_W-1:0] r_zero_cnt;
    logic [CNT_W-1:0] r_denorm_cnt;
    logic [CNT_W-1:0] r_normal_cnt;
    logic [CNT_W-1:0] r_inf_cnt;
    logic [CNT_W-1:0] r_nan_cnt;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_overflow;

    cls_e             w_class;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [34:0]      w_head;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Classify the incoming word from its exponent and mantissa fields; sign is ignored.
    always_comb begin
        // NOTE: default assigned first so every path drives w_class and no latch is inferred.
        w_class = CLS_NORMAL;
        if (in_data[30:23] == 8'hFF) begin
            w_class = (in_data[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
        end else if (in_data[30:23] == 8'h00) begin
            w_class = (in_data[22:0] != 23'd0) ? CLS_DENORM : CLS_ZERO;
        end
    end

    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // A pop needs a visible head, so an empty FIFO can never pop; a full
    // FIFO may still accept a push when the head leaves in the same cycle.
    assign w_pop   = !w_empty && out_ready;
    assign w_push  = in_valid && (!w_full || w_pop);
    assign w_drop  = in_valid && w_full && !w_pop;

    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    // Head is driven from registered storage only; no in->out combinational path.
    assign out_valid  = !w_empty;
    assign out_data   = w_empty ? 32'd0 : w_head[31:0];
    assign out_class  = w_empty ? 3'd0  : w_head[34:32];
    assign full       = w_full;
    assign empty      = w_empty;

    assign zero_cnt   = r_zero_cnt;
    assign denorm_cnt = r_denorm_cnt;
    assign normal_cnt = r_normal_cnt;
    assign inf_cnt    = r_inf_cnt;
    assign nan_cnt    = r_nan_cnt;
    assign drop_cnt   = r_drop_cnt;
    assign overflow   = r_overflow;

    // Write the classified entry into storage on every accepted push.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; validity is defined solely by the pointers.
        if (arst_n && w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_class, in_data};
        end
    end

    // Advance read/write pointers; reset discards every buffered entry.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!arst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Statistics: reset beats clear, clear beats increment; counters saturate.
    always_ff @(posedge clk) begin
        if (!arst_n || clr_stats) begin
            r_zero_cnt   <= '0;
            r_denorm_cnt <= '0;
            r_normal_cnt <= '0;
            r_inf_cnt    <= '0;
            r_nan_cnt    <= '0;
            r_drop_cnt   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push) begin
                case (w_class)
                    CLS_ZERO:   r_zero_cnt   <= sat_inc(r_zero_cnt);
                    CLS_DENORM: r_denorm_cnt <= sat_inc(r_denorm_cnt);
                    CLS_NORMAL: r_normal_cnt <= sat_inc(r_normal_cnt);
                    CLS_INF:    r_inf_cnt    <= sat_inc(r_inf_cnt);
                    CLS_NAN:    r_nan_cnt    <= sat_inc(r_nan_cnt);
                    default:    ;
                endcase
            end
            if (w_drop) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_result_collector.sv
// Bench for fpu_result_collector. Two instances share every input: one with
// 16-bit counters and one with 2-bit counters, so saturation is visible.
// A queue-based model tracks the expected FIFO contents and unbounded event
// counts; expected counter values are those counts clipped to each width.

module tb_fpu_result_collector;

    localparam int DEPTH = 8;

    logic        clk;
    logic        arst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        clr_stats;

    logic        out_valid,  out_valid2;
    logic [31:0] out_data,   out_data2;
    logic [2:0]  out_class,  out_class2;
    logic        full,       full2;
    logic        empty,      empty2;
    logic        overflow,   overflow2;
    logic [15:0] zero_cnt, denorm_cnt, normal_cnt, inf_cnt, nan_cnt, drop_cnt;
    logic [1:0]  zero_cnt2, denorm_cnt2, normal_cnt2, inf_cnt2, nan_cnt2, drop_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    fpu_result_collector #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
        .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_class(out_class), .full(full), .empty(empty), .clr_stats(clr_stats),
        .zero_cnt(zero_cnt), .denorm_cnt(denorm_cnt), .normal_cnt(normal_cnt),
        .inf_cnt(inf_cnt), .nan_cnt(nan_cnt), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    fpu_result_collector #(.DEPTH(DEPTH), .CNT_W(2)) u_dut2 (
        .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .out_valid(out_valid2), .out_data(out_data2),
        .out_class(out_class2), .full(full2), .empty(empty2), .clr_stats(clr_stats),
        .zero_cnt(zero_cnt2), .denorm_cnt(denorm_cnt2), .normal_cnt(normal_cnt2),
        .inf_cnt(inf_cnt2), .nan_cnt(nan_cnt2), .drop_cnt(drop_cnt2), .overflow(overflow2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [34:0] mq[$];
    int          mcnt[5];
    int          mdrop;
    bit          movf;

    function automatic int ref_class(input logic [31:0] w);
        int e;
        int m;
        e = int'(w[30:23]);
        m = int'(w[22:0]);
        if (e == 255) return (m != 0) ? 4 : 3;
        if (e == 0)   return (m != 0) ? 1 : 0;
        return 2;
    endfunction

    function automatic int clip(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(posedge clk) begin
        bit pop_e;
        bit push_e;
        bit drop_e;
        if (!arst_n) begin
            mq.delete();
            for (int k = 0; k < 5; k++) mcnt[k] = 0;
            mdrop = 0;
            movf  = 1'b0;
        end else begin
            pop_e  = (mq.size() > 0) && out_ready;
            push_e = in_valid && ((mq.size() < DEPTH) || pop_e);
            drop_e = in_valid && !push_e;
            if (clr_stats) begin
                for (int k = 0; k < 5; k++) mcnt[k] = 0;
                mdrop = 0;
                movf  = 1'b0;
            end else begin
                if (push_e) mcnt[ref_class(in_data)]++;
                if (drop_e) begin
                    mdrop++;
                    movf = 1'b1;
                end
            end
            if (pop_e)  void'(mq.pop_front());
            if (push_e) mq.push_back({3'(ref_class(in_data)), in_data});
        end
    end

    // ---------------- per-cycle compare against model ----------------
    task automatic compare_all();
        logic [15:0] c1[5];
        logic [1:0]  c2[5];
        bit v;
        c1 = '{zero_cnt, denorm_cnt, normal_cnt, inf_cnt, nan_cnt};
        c2 = '{zero_cnt2, denorm_cnt2, normal_cnt2, inf_cnt2, nan_cnt2};
        v = (mq.size() > 0);
        check("out_valid",  out_valid,  v);
        check("out_valid2", out_valid2, v);
        if (v) begin
            check("out_data",   out_data,   mq[0][31:0]);
            check("out_class",  out_class,  mq[0][34:32]);
            check("out_data2",  out_data2,  mq[0][31:0]);
            check("out_class2", out_class2, mq[0][34:32]);
        end
        check("full",   full,   mq.size() == DEPTH);
        check("empty",  empty,  mq.size() == 0);
        check("full2",  full2,  mq.size() == DEPTH);
        check("empty2", empty2, mq.size() == 0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("cls_cnt[%0d]", k),  c1[k], clip(mcnt[k], 65535));
            check($sformatf("cls_cnt2[%0d]", k), c2[k], clip(mcnt[k], 3));
        end
        check("drop_cnt",  drop_cnt,  clip(mdrop, 65535));
        check("drop_cnt2", drop_cnt2, clip(mdrop, 3));
        check("overflow",  overflow,  movf);
        check("overflow2", overflow2, movf);
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            compare_all();
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] t2_data[5]  = '{32'h7F800000, 32'h7FC00000, 32'h00400000, 32'h41700000, 32'h80000000};
    logic [2:0]  t2_class[5] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0};

    initial begin
        arst_n    = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        clr_stats = 1'b0;

        // 1: reset for two cycles
        step();
        step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data",  out_data,  32'd0);
        check("rst_out_class", out_class, 3'd0);
        check("rst_empty",     empty,     1'b1);
        check("rst_full",      full,      1'b0);
        check("rst_normal",    normal_cnt, 16'd0);
        check("rst_drop",      drop_cnt,  16'd0);
        arst_n = 1'b1;
        step();

        // 2: one of each class, back-to-back, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = t2_data[i];
            step();
            check("t2_data",  out_data,  t2_data[i]);
            check("t2_class", out_class, t2_class[i]);
        end
        in_valid = 1'b0;
        step();
        check("t2_inf",    inf_cnt,    16'd1);
        check("t2_nan",    nan_cnt,    16'd1);
        check("t2_denorm", denorm_cnt, 16'd1);
        check("t2_normal", normal_cnt, 16'd1);
        check("t2_zero",   zero_cnt,   16'd1);
        check("t2_empty",  empty,      1'b1);

        // 3: fill with consumer stalled, ninth push is dropped
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 32'h41200000 + 32'(i);
            step();
            if (i == 7) check("t3_full", full, 1'b1);
        end
        in_valid = 1'b0;
        check("t3_drop", drop_cnt, 16'd1);
        check("t3_ovf",  overflow, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t3_drain", out_data, 32'h41200000 + 32'(i));
            step();
        end
        check("t3_empty", empty, 1'b1);

        // 4: push and pop together while full, no drop
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'h41200010 + 32'(i);
            step();
        end
        check("t4_full_before", full, 1'b1);
        in_data   = 32'h40A00000;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("t4_full_after", full,     1'b1);
        check("t4_drop",       drop_cnt, 16'd1);
        for (int i = 0; i < 8; i++) begin
            check("t4_drain", out_data, (i < 7) ? 32'h41200011 + 32'(i) : 32'h40A00000);
            step();
        end
        check("t4_empty", empty, 1'b1);

        // 5: reset in the middle of a drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h3F800000 + 32'(i);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        arst_n = 1'b0;
        step();
        arst_n = 1'b1;
        check("t5_empty",     empty,      1'b1);
        check("t5_out_valid", out_valid,  1'b0);
        check("t5_normal",    normal_cnt, 16'd0);
        check("t5_drop",      drop_cnt,   16'd0);
        check("t5_ovf",       overflow,   1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hC1200000;
        step();
        in_valid = 1'b0;
        check("t5_valid", out_valid, 1'b1);
        check("t5_data",  out_data,  32'hC1200000);
        check("t5_class", out_class, 3'd2);
        out_ready = 1'b1;
        step();

        // 6: 2-bit counters saturate, then clear coincides with a push
        in_valid = 1'b1;
        in_data  = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) step();
        in_valid = 1'b0;
        step();
        check("t6_nan_sat", nan_cnt2, 2'd3);
        check("t6_nan_16",  nan_cnt,  16'd5);
        clr_stats = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h00000000;
        step();
        clr_stats = 1'b0;
        in_valid  = 1'b0;
        check("t6_nan_clr",   nan_cnt2,   2'd0);
        check("t6_zero_clr",  zero_cnt2,  2'd0);
        check("t6_zero16",    zero_cnt,   16'd0);
        check("t6_normal16",  normal_cnt, 16'd0);
        check("t6_valid",     out_valid,  1'b1);
        check("t6_data",      out_data,   32'h00000000);
        check("t6_class",     out_class,  3'd0);
        step();
        check("t6_empty", empty, 1'b1);

        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
